// File: rtl/mc_alu_control.sv
// Multicycle ARM-subset control unit: FSM sequencing, ALU decode, condition check and NZCV flags.
// Optional macro ALU_EXT_EN enables the EOR, MOV, CMP and TST commands.
module mc_alu_control #(
    parameter int unsigned FETCH_WAIT = 0,
    parameter int unsigned MEM_WAIT   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] Flags,
    output logic       Busy
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecR,
        StExecI,
        StAluWb,
        StBranch
    } state_e;

    localparam logic [3:0] FetchLast = 4'(FETCH_WAIT);
    localparam logic [3:0] MemLast   = 4'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] flags_q;
    logic       cond_ex, cond_ex_q;

    logic       cmd_ok, cmd_wb, cmd_cv, cmd_cmp;
    logic [2:0] alu_op;
    logic       in_exec, flag_we;

    logic fn, fz, fc, fv;
    assign {fn, fz, fc, fv} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        unique case (Cond)
            4'b0000: cond_ex = fz;
            4'b0001: cond_ex = ~fz;
            4'b0010: cond_ex = fc;
            4'b0011: cond_ex = ~fc;
            4'b0100: cond_ex = fn;
            4'b0101: cond_ex = ~fn;
            4'b0110: cond_ex = fv;
            4'b0111: cond_ex = ~fv;
            4'b1000: cond_ex = fc & ~fz;
            4'b1001: cond_ex = ~fc | fz;
            4'b1010: cond_ex = (fn == fv);
            4'b1011: cond_ex = (fn != fv);
            4'b1100: cond_ex = ~fz & (fn == fv);
            4'b1101: cond_ex = fz | (fn != fv);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        cmd_ok  = 1'b0;
        cmd_wb  = 1'b0;
        cmd_cv  = 1'b0;
        cmd_cmp = 1'b0;
        alu_op  = 3'b000;
        case (Funct[4:1])
            4'b0100: begin cmd_ok = 1'b1; cmd_wb = 1'b1; cmd_cv = 1'b1; alu_op = 3'b000; end
            4'b0010: begin cmd_ok = 1'b1; cmd_wb = 1'b1; cmd_cv = 1'b1; alu_op = 3'b001; end
            4'b0000: begin cmd_ok = 1'b1; cmd_wb = 1'b1; alu_op = 3'b010; end
            4'b1100: begin cmd_ok = 1'b1; cmd_wb = 1'b1; alu_op = 3'b011; end
`ifdef ALU_EXT_EN
            4'b0001: begin cmd_ok = 1'b1; cmd_wb = 1'b1; alu_op = 3'b100; end
            4'b1101: begin cmd_ok = 1'b1; cmd_wb = 1'b1; alu_op = 3'b101; end
            4'b1010: begin cmd_ok = 1'b1; cmd_cv = 1'b1; cmd_cmp = 1'b1; alu_op = 3'b001; end
            4'b1000: begin cmd_ok = 1'b1; cmd_cmp = 1'b1; alu_op = 3'b010; end
`endif
            default: ;
        endcase
    end

    assign in_exec = (state_q == StExecR) || (state_q == StExecI);
    // Compares always set N/Z; S bit is ignored for them.
    assign flag_we = in_exec && cmd_ok && (Funct[0] || cmd_cmp) && cond_ex;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        Busy       = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (cnt_q == FetchLast) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    cnt_d     = 4'd0;
                    state_d   = StDecode;
                end else begin
                    Busy  = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDecode: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                unique case (Op)
                    2'b01:   state_d = StMemAdr;
                    2'b00:   state_d = Funct[5] ? StExecI : StExecR;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? StMemRd : StMemWr;
            end
            StMemRd: begin
                AdrSrc = 1'b1;
                if (cnt_q == MemLast) begin
                    cnt_d   = 4'd0;
                    state_d = StMemWb;
                end else begin
                    Busy  = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex;
                state_d   = StFetch;
            end
            StMemWr: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex;
                state_d  = StFetch;
            end
            StExecR, StExecI: begin
                ALUSrcB    = (state_q == StExecI) ? 2'b01 : 2'b00;
                ALUControl = alu_op;
                state_d    = (cmd_ok && cmd_wb) ? StAluWb : StFetch;
            end
            StAluWb: begin
                // Condition captured in EXEC, before any flag update this instruction made.
                RegWrite = cond_ex_q;
                PCWrite  = cond_ex_q && (Rd == 4'hf);
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase

        ImmSrc = Op;
        RegSrc = {Op == 2'b01, Op == 2'b10};

        if (!reset) begin
            PCWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            IRWrite    = 1'b0;
            AdrSrc     = 1'b0;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ResultSrc  = 2'b00;
            ImmSrc     = 2'b00;
            RegSrc     = 2'b00;
            ALUControl = 3'b000;
            Busy       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StFetch;
            cnt_q     <= 4'd0;
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cond_ex_q <= cond_ex;
            if (flag_we) begin
                flags_q[3:2] <= ALUFlags[3:2];
                if (cmd_cv) begin
                    flags_q[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    assign Flags = flags_q;

endmodule

// File: tb/tb_mc_alu_control.sv
// Scoreboard bench for mc_alu_control: per-instruction cycle expectations from a behavioural model.
module tb_mc_alu_control;

    localparam int FW = 2;
    localparam int MW = 3;

    typedef struct packed {
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       irw;
        logic       adr;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [2:0] alu;
        logic [3:0] flags;
        logic       busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, Busy;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags;

    mc_alu_control #(
        .FETCH_WAIT(FW),
        .MEM_WAIT  (MW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Cond),
        .Op        (Op),
        .Funct     (Funct),
        .Rd        (Rd),
        .ALUFlags  (ALUFlags),
        .PCWrite   (PCWrite),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .ALUControl(ALUControl),
        .Flags     (Flags),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    vec_t       exp_q[$];
    string      name_q[$];
    logic [3:0] model_flags = 4'b0000;
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] cmds[8] = '{4'h4, 4'h2, 4'h0, 4'hc, 4'h1, 4'hd, 4'ha, 4'h8};

    vec_t  act;
    vec_t  mon_e;
    string mon_n;
    assign act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                  ALUControl, Flags, Busy};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            n_vec++;
            if (act !== mon_e) begin
                n_err++;
                $display("FAIL %s: got %b want %b (pcw memw regw irw adr srca srcb res alu nzcv busy)",
                         mon_n, act, mon_e);
            end
        end
    end

    // ARM condition: pairs of codes share a base test, odd code inverts it.
    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit nn, zz, cc, vv, base;
        nn = f[3]; zz = f[2]; cc = f[1]; vv = f[0];
        case (c[3:1])
            3'd0:    base = zz;
            3'd1:    base = cc;
            3'd2:    base = nn;
            3'd3:    base = vv;
            3'd4:    base = cc && !zz;
            3'd5:    base = (nn == vv);
            3'd6:    base = !zz && (nn == vv);
            default: return !c[0];
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic void cmd_info(input logic [3:0] cmd, output bit ok, output logic [2:0] code,
                                     output bit wb, output bit cv, output bit forced);
        ok = 1; wb = 1; cv = 0; forced = 0; code = 3'd0;
        case (cmd)
            4'h4: cv = 1;
            4'h2: begin code = 3'd1; cv = 1; end
            4'h0: code = 3'd2;
            4'hc: code = 3'd3;
`ifdef ALU_EXT_EN
            4'h1: code = 3'd4;
            4'hd: code = 3'd5;
            4'ha: begin code = 3'd1; cv = 1; wb = 0; forced = 1; end
            4'h8: begin code = 3'd2; wb = 0; forced = 1; end
`endif
            default: begin ok = 0; wb = 0; end
        endcase
    endfunction

    function automatic vec_t blank(input logic [3:0] f);
        vec_t v;
        v = '0;
        v.flags = f;
        return v;
    endfunction

    task automatic do_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(blank(model_flags));
            name_q.push_back($sformatf("reset#%0d", i));
            @(posedge clk);
            #1;
            model_flags = 4'b0000;
        end
        reset = 1'b1;
    endtask

    // abort_at < 0 runs the whole instruction; otherwise reset hits after that many cycles.
    task automatic run_instr(input string nm, input logic [3:0] cnd, input logic [1:0] op,
                             input logic [5:0] fn, input logic [3:0] rd, input logic [3:0] af,
                             input int abort_at);
        vec_t       seq[$];
        vec_t       v;
        bit         ce, ok, wb, cv, forced;
        logic [2:0] code;
        logic [3:0] nf;
        int         n;
        ce = cond_true(cnd, model_flags);
        nf = model_flags;
        for (int i = 0; i < FW; i++) begin
            v = blank(model_flags); v.busy = 1; seq.push_back(v);
        end
        v = blank(model_flags);
        v.irw = 1; v.pcw = 1; v.srca = 2'b01; v.srcb = 2'b10; v.res = 2'b10;
        seq.push_back(v);
        v = blank(model_flags);
        v.srca = 2'b01; v.srcb = 2'b10; v.res = 2'b10;
        seq.push_back(v);
        case (op)
            2'b01: begin
                v = blank(model_flags); v.srcb = 2'b01; seq.push_back(v);
                if (fn[0]) begin
                    for (int i = 0; i <= MW; i++) begin
                        v = blank(model_flags); v.adr = 1; v.busy = (i < MW); seq.push_back(v);
                    end
                    v = blank(model_flags); v.res = 2'b01; v.regw = ce; seq.push_back(v);
                end else begin
                    v = blank(model_flags); v.adr = 1; v.memw = ce; seq.push_back(v);
                end
            end
            2'b10: begin
                v = blank(model_flags);
                v.srca = 2'b10; v.srcb = 2'b01; v.res = 2'b10; v.pcw = ce;
                seq.push_back(v);
            end
            2'b00: begin
                cmd_info(fn[4:1], ok, code, wb, cv, forced);
                v = blank(model_flags);
                v.srcb = fn[5] ? 2'b01 : 2'b00;
                v.alu = ok ? code : 3'd0;
                seq.push_back(v);
                if (ok && (fn[0] || forced) && ce) begin
                    nf[3:2] = af[3:2];
                    if (cv) nf[1:0] = af[1:0];
                end
                if (ok && wb) begin
                    v = blank(nf); v.regw = ce; v.pcw = ce && (rd == 4'hf); seq.push_back(v);
                end
            end
            default: ;
        endcase
        Cond = cnd; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
        n = (abort_at < 0) ? seq.size() : abort_at;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(seq[i]);
            name_q.push_back($sformatf("%s#%0d", nm, i));
        end
        repeat (n) @(posedge clk);
        #1;
        if (abort_at < 0) model_flags = nf;
        else do_reset(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rc, rr, ra;
        logic [1:0] ro;
        logic [5:0] rf;
        reset = 1'b0;
        Cond = 4'he; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(3);

        run_instr("adds", 4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0110, -1);
        run_instr("cmp_z1", 4'b1110, 2'b00, 6'b010101, 4'd2, 4'b0100, -1);
        run_instr("beq_t", 4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);
        run_instr("cmp_z0", 4'b1110, 2'b00, 6'b010101, 4'd2, 4'b0000, -1);
        run_instr("beq_f", 4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);
        run_instr("ldr", 4'b1110, 2'b01, 6'b011001, 4'd3, 4'b0000, -1);
        run_instr("str", 4'b1110, 2'b01, 6'b011000, 4'd3, 4'b0000, -1);
        run_instr("eor", 4'b1110, 2'b00, 6'b000010, 4'd4, 4'b1000, -1);
        run_instr("subs_pc", 4'b1110, 2'b00, 6'b100101, 4'hf, 4'b1011, -1);
        run_instr("op11", 4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000, -1);
        run_instr("ldr_abort", 4'b1110, 2'b01, 6'b011001, 4'd5, 4'b0000, FW + 4);
        run_instr("post_rst", 4'b1110, 2'b00, 6'b011001, 4'd6, 4'b1100, -1);
        run_instr("never", 4'b1111, 2'b00, 6'b001001, 4'd1, 4'b0110, -1);

        for (int k = 0; k < 150; k++) begin
            ro = 2'($urandom_range(0, 3));
            rc = ($urandom_range(0, 1) == 0) ? 4'he : 4'($urandom_range(0, 15));
            rf = 6'($urandom_range(0, 63));
            if (ro == 2'b00 && $urandom_range(0, 3) != 0) rf[4:1] = cmds[$urandom_range(0, 7)];
            rr = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            run_instr($sformatf("rnd%0d", k), rc, ro, rf, rr, ra, -1);
        end

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
